// File: rtl/picprint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : picprint_pkg
// Purpose  : Shared definitions for the picture-printer frame sequencer:
//            state encoding, serial line levels and a frame-length helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package picprint_pkg;

   // Sequencer state encoding
   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PREAMBLE  = 3'd1;
   localparam logic [2:0] ST_ROW_START = 3'd2;
   localparam logic [2:0] ST_PIXELS    = 3'd3;
   localparam logic [2:0] ST_ROW_STOP  = 3'd4;
   localparam logic [2:0] ST_FINISH    = 3'd5;

   // Serial line levels
   localparam logic TX_IDLE   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Number of serial bits in one frame: preamble plus each row framed by
   // one start bit and one stop bit.
   function automatic int unsigned FRAME_BITS(input int unsigned w,
                                              input int unsigned h,
                                              input int unsigned p);
      return p + h * (w + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/picprint_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : picprint_bit_timer
// Purpose  : Bit-period divider. Counts 0..CLK_DIV-1 while enabled and
//            flags the last cycle of each bit period with bit_end.
// Ports    : clk      - clock
//            reset    - synchronous, active-high reset
//            enable   - count this cycle (held counter when low)
//            clear    - synchronous restart of the bit period
//            bit_end  - high in the final enabled cycle of a bit period
// Revision : 1.0 - initial release
// ============================================================================
module picprint_bit_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic bit_end
);

   localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last_count = c_cnt_w'(CLK_DIV - 1);

   logic [c_cnt_w-1:0] r_count;

   // Combinational from the counter so the sequencer can act on the same
   // edge that wraps the period; gated by enable so a paused bit never ends.
   assign bit_end = enable && (r_count == c_last_count);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_count <= '0;
      end else if (bit_end) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + c_cnt_w'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/picprint_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : picprint_frame_ctrl
// Purpose  : Picture-printer frame sequencer. On start, walks the pixel ROM
//            row by row and emits a framed serial stream: an alternating
//            preamble, then each row as start bit, IMG_W pixels, stop bit.
//            Every bit is held CLK_DIV cycles; pause freezes progress.
// Ports    : clk       - clock
//            reset     - synchronous, active-high reset
//            start     - frame request, honoured only in IDLE
//            pause     - hold bit timer and sequencing while high
//            pix_data  - pixel value at pix_addr (combinational ROM read)
//            pix_addr  - pixel index row*IMG_W + col
//            tx_out    - registered serial output, idles high
//            busy      - high while a frame is being emitted
//            done      - one-cycle pulse after the final stop bit
//            row_idx   - current row, status only
// Revision : 1.0 - initial release
// ============================================================================
module picprint_frame_ctrl
   import picprint_pkg::*;
#(
   parameter int IMG_W        = 40,
   parameter int IMG_H        = 42,
   parameter int CLK_DIV      = 4,
   parameter int PREAMBLE_LEN = 8,
   parameter int ADDR_W       = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              pix_data,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              tx_out,
   output logic              busy,
   output logic              done,
   output logic [5:0]        row_idx
);

   localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int c_pre_w = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;

   localparam logic [c_col_w-1:0] c_last_col  = c_col_w'(IMG_W - 1);
   localparam logic [c_pre_w-1:0] c_last_pre  = c_pre_w'(PREAMBLE_LEN - 1);
   localparam logic [5:0]         c_last_row  = 6'(IMG_H - 1);
   localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(IMG_W * IMG_H - 1);

   // The preamble opens with a 1 and alternates from there.
   localparam logic c_pre_first = 1'b1;

   state_t              r_state;
   logic                r_tx;
   logic                r_busy;
   logic                r_done;
   logic [c_pre_w-1:0]  r_pre_cnt;
   logic [c_col_w-1:0]  r_col;
   logic [5:0]          r_row;
   logic [ADDR_W-1:0]   r_addr;

   logic                w_accept;
   logic                w_timer_en;
   logic                w_bit_end;
   logic [ADDR_W-1:0]   w_addr_next;

   assign w_accept   = (r_state == ST_IDLE) && start;
   assign w_timer_en = r_busy && !pause;

   // r_addr always points at the next pixel to be loaded, so the ROM has a
   // full cycle (at least) to settle before the load edge. It stops on the
   // last pixel of the frame instead of running past the image.
   assign w_addr_next = (r_addr == c_last_addr) ? r_addr : (r_addr + ADDR_W'(1));

   picprint_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .enable  (w_timer_en),
      .clear   (w_accept),
      .bit_end (w_bit_end)
   );

   // Each branch decides the next bit on the edge that ends the current
   // one, so tx_out only ever changes on a bit boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_tx      <= TX_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pre_cnt <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_addr    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_PREAMBLE;
                  r_busy    <= 1'b1;
                  r_tx      <= c_pre_first;
                  r_pre_cnt <= '0;
                  r_col     <= '0;
                  r_row     <= '0;
                  r_addr    <= '0;
               end
            end

            ST_PREAMBLE: begin
               if (w_bit_end) begin
                  if (r_pre_cnt == c_last_pre) begin
                     r_state <= ST_ROW_START;
                     r_tx    <= START_BIT;
                  end else begin
                     r_pre_cnt <= r_pre_cnt + c_pre_w'(1);
                     r_tx      <= ~r_tx;
                  end
               end
            end

            ST_ROW_START: begin
               if (w_bit_end) begin
                  r_state <= ST_PIXELS;
                  r_col   <= '0;
                  r_tx    <= pix_data;
                  r_addr  <= w_addr_next;
               end
            end

            ST_PIXELS: begin
               if (w_bit_end) begin
                  if (r_col == c_last_col) begin
                     r_state <= ST_ROW_STOP;
                     r_tx    <= STOP_BIT;
                  end else begin
                     r_col  <= r_col + c_col_w'(1);
                     r_tx   <= pix_data;
                     r_addr <= w_addr_next;
                  end
               end
            end

            ST_ROW_STOP: begin
               if (w_bit_end) begin
                  if (r_row == c_last_row) begin
                     r_state <= ST_FINISH;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_tx    <= TX_IDLE;
                  end else begin
                     r_row   <= r_row + 6'd1;
                     r_state <= ST_ROW_START;
                     r_tx    <= START_BIT;
                  end
               end
            end

            // Single cycle of done; start is deliberately not looked at
            // here, so a held request is taken up in the following IDLE.
            ST_FINISH: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_tx    <= TX_IDLE;
            end
         endcase
      end
   end

   assign pix_addr = r_addr;
   assign tx_out   = r_tx;
   assign busy     = r_busy;
   assign done     = r_done;
   assign row_idx  = r_row;

endmodule
`default_nettype wire

// File: tb/tb_picprint_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_picprint_frame_ctrl
// Purpose  : Self-checking bench for picprint_frame_ctrl. A small instance
//            (4x2 image, CLK_DIV=3, 4-bit preamble) covers timing, pause,
//            restart and reset rules; a default-size instance with CLK_DIV=1
//            covers the full 1772-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picprint_frame_ctrl;
   import picprint_pkg::*;

   localparam int SW    = 4;
   localparam int SH    = 2;
   localparam int SDIV  = 3;
   localparam int SP    = 4;
   localparam int SBITS = int'(FRAME_BITS(SW, SH, SP));

   localparam int DW    = 40;
   localparam int DH    = 42;
   localparam int DP    = 8;
   localparam int DBITS = int'(FRAME_BITS(DW, DH, DP));

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // small instance
   logic        s_reset, s_start, s_pause, s_pix_data;
   logic [11:0] s_addr;
   logic        s_tx, s_busy, s_done;
   logic [5:0]  s_row;
   logic        s_rom [0:4095];
   assign s_pix_data = s_rom[s_addr];

   // default-size instance
   logic        d_reset, d_start, d_pause, d_pix_data;
   logic [11:0] d_addr;
   logic        d_tx, d_busy, d_done;
   logic [5:0]  d_row;
   logic        d_rom [0:4095];
   assign d_pix_data = d_rom[d_addr];

   picprint_frame_ctrl #(
      .IMG_W (SW), .IMG_H (SH), .CLK_DIV (SDIV), .PREAMBLE_LEN (SP), .ADDR_W (12)
   ) u_small (
      .clk (clk), .reset (s_reset), .start (s_start), .pause (s_pause),
      .pix_data (s_pix_data), .pix_addr (s_addr), .tx_out (s_tx),
      .busy (s_busy), .done (s_done), .row_idx (s_row)
   );

   picprint_frame_ctrl #(
      .IMG_W (DW), .IMG_H (DH), .CLK_DIV (1), .PREAMBLE_LEN (DP), .ADDR_W (12)
   ) u_dflt (
      .clk (clk), .reset (d_reset), .start (d_start), .pause (d_pause),
      .pix_data (d_pix_data), .pix_addr (d_addr), .tx_out (d_tx),
      .busy (d_busy), .done (d_done), .row_idx (d_row)
   );

   bit exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected serial bit stream of one frame, straight from the framing rules.
   function automatic void build_exp(input bit big);
      int w, h, p;
      w = big ? DW : SW;
      h = big ? DH : SH;
      p = big ? DP : SP;
      exp_q.delete();
      for (int i = 0; i < p; i++) exp_q.push_back((i % 2) == 0);
      for (int r = 0; r < h; r++) begin
         exp_q.push_back(1'b0);
         for (int c = 0; c < w; c++)
            exp_q.push_back(big ? d_rom[r * w + c] : s_rom[r * w + c]);
         exp_q.push_back(1'b1);
      end
   endfunction

   // Runs one small-instance frame starting from an IDLE cycle and checks it
   // cycle by cycle. pmode: 0 no pause, 1 five-cycle pause in the 2nd cycle
   // of pixel bit 2 of row 0, 2 random pause. glitch_at: frame cycle with a
   // one-cycle start pulse. abort_at: return as soon as this bit is on the line.
   task automatic run_small(input int pmode, input bit hold, input int glitch_at,
                            input int abort_at, input bit use_vec, input int exp_cycles);
      logic [15:0] vec;
      int idx, prog, cyc, pleft, er;
      bit fired, pz;
      vec = 16'b1010_010101_001111;
      if (use_vec) begin
         exp_q.delete();
         for (int i = 0; i < SBITS; i++) exp_q.push_back(vec[15 - i]);
      end else begin
         build_exp(1'b0);
      end
      idx = 0; prog = 0; cyc = 0; pleft = 0; fired = 0;
      s_start = 1'b1;
      step();
      if (!hold) s_start = 1'b0;
      while (idx < SBITS && cyc < 1000) begin
         cyc++;
         chk("s_tx", 32'(s_tx), 32'(exp_q[idx]));
         chk("s_busy", 32'(s_busy), 32'd1);
         chk("s_done", 32'(s_done), 32'd0);
         er = (idx < SP) ? 0 : (idx - SP) / (SW + 2);
         chk("s_row", 32'(s_row), 32'(er));
         chk("s_addr_range", 32'(s_addr <= 12'(SW * SH - 1)), 32'd1);
         if (idx == abort_at) begin
            s_pause = 1'b0;
            return;
         end
         pz = 1'b0;
         if (pmode == 1) begin
            if (!fired && idx == SP + 3 && prog == 1) begin
               fired = 1;
               pleft = 5;
            end
            if (pleft > 0) begin
               pz = 1'b1;
               pleft--;
            end
         end else if (pmode == 2) begin
            pz = ($urandom_range(0, 3) == 0);
         end
         s_pause = pz;
         if (cyc == glitch_at) s_start = 1'b1;
         else if (!hold) s_start = 1'b0;
         if (!pz) begin
            prog++;
            if (prog == SDIV) begin
               prog = 0;
               idx++;
            end
         end
         step();
      end
      s_pause = 1'b0;
      if (!hold) s_start = 1'b0;
      chk("s_frame_complete", 32'(idx), 32'(SBITS));
      if (exp_cycles >= 0) chk("s_frame_cycles", 32'(cyc), 32'(exp_cycles));
      chk("s_fin_done", 32'(s_done), 32'd1);
      chk("s_fin_busy", 32'(s_busy), 32'd0);
      chk("s_fin_tx", 32'(s_tx), 32'd1);
      step();
      chk("s_idle_done", 32'(s_done), 32'd0);
      chk("s_idle_busy", 32'(s_busy), 32'd0);
      chk("s_idle_tx", 32'(s_tx), 32'd1);
   endtask

   task automatic run_dflt();
      int cyc, maxaddr;
      build_exp(1'b1);
      cyc = 0; maxaddr = 0;
      d_start = 1'b1;
      step();
      d_start = 1'b0;
      while (d_busy && cyc < 4000) begin
         if (cyc < DBITS) chk("d_tx", 32'(d_tx), 32'(exp_q[cyc]));
         chk("d_done_low", 32'(d_done), 32'd0);
         if (int'(d_addr) > maxaddr) maxaddr = int'(d_addr);
         cyc++;
         step();
      end
      chk("d_busy_cycles", 32'(cyc), 32'(DBITS));
      chk("d_done", 32'(d_done), 32'd1);
      chk("d_max_addr", 32'(maxaddr), 32'(DW * DH - 1));
      step();
      chk("d_idle_busy", 32'(d_busy), 32'd0);
   endtask

   initial begin
      s_reset = 1'b1; s_start = 1'b0; s_pause = 1'b0;
      d_reset = 1'b1; d_start = 1'b0; d_pause = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         s_rom[i] = 1'b0;
         d_rom[i] = 1'b1;
      end

      // reset held three cycles, then idle with start low
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_tx", 32'(s_tx), 32'd1);
         chk("rst_busy", 32'(s_busy), 32'd0);
         chk("rst_done", 32'(s_done), 32'd0);
         chk("rst_addr", 32'(s_addr), 32'd0);
         chk("rst_row", 32'(s_row), 32'd0);
         chk("rst_d_tx", 32'(d_tx), 32'd1);
      end
      s_reset = 1'b0;
      d_reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_pause = (i % 2 == 0);
         step();
         chk("idle_tx", 32'(s_tx), 32'd1);
         chk("idle_busy", 32'(s_busy), 32'd0);
         chk("idle_done", 32'(s_done), 32'd0);
         chk("idle_addr", 32'(s_addr), 32'd0);
         chk("idle_d_busy", 32'(d_busy), 32'd0);
      end
      s_pause = 1'b0;

      // ROM 1010_0111, address 0 first
      s_rom[0] = 1; s_rom[1] = 0; s_rom[2] = 1; s_rom[3] = 0;
      s_rom[4] = 0; s_rom[5] = 1; s_rom[6] = 1; s_rom[7] = 1;

      run_small(0, 1'b0, -1, -1, 1'b1, 48);
      run_small(1, 1'b0, -1, -1, 1'b1, 53);

      // start held through two frames: one done each, restart 2 cycles after done
      run_small(0, 1'b1, -1, -1, 1'b1, 48);
      run_small(0, 1'b1, -1, -1, 1'b1, 48);
      s_start = 1'b0;
      step();
      chk("hold_release_busy", 32'(s_busy), 32'd0);
      chk("hold_release_done", 32'(s_done), 32'd0);

      // start pulse mid-frame is ignored
      run_small(0, 1'b0, 20, -1, 1'b1, 48);

      // reset during PIXELS of row 1
      run_small(0, 1'b0, -1, SP + (SW + 2) + 2, 1'b1, -1);
      s_reset = 1'b1;
      step();
      s_reset = 1'b0;
      chk("mid_rst_tx", 32'(s_tx), 32'd1);
      chk("mid_rst_busy", 32'(s_busy), 32'd0);
      chk("mid_rst_addr", 32'(s_addr), 32'd0);
      chk("mid_rst_done", 32'(s_done), 32'd0);
      chk("mid_rst_row", 32'(s_row), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_done", 32'(s_done), 32'd0);
         chk("post_rst_busy", 32'(s_busy), 32'd0);
      end
      run_small(0, 1'b0, -1, -1, 1'b1, 48);

      // random pixel contents and random pause
      for (int k = 0; k < 6; k++) begin
         for (int a = 0; a < SW * SH; a++) s_rom[a] = 1'($urandom_range(0, 1));
         run_small(2, 1'b0, -1, -1, 1'b0, -1);
      end

      // default geometry, CLK_DIV=1: all-ones ROM, then random ROM
      run_dflt();
      for (int a = 0; a < DW * DH; a++) d_rom[a] = 1'($urandom_range(0, 1));
      run_dflt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
